// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the parametrised synchronous FIFO
package fifo_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - pointers, occupancy, status flags and sticky error flags
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    localparam int ADDR_W  = fifo_addr_w(DEPTH),
    localparam int CNT_W   = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              winc,
    input  logic              rinc,
    input  logic              clr_err,
    output logic              w_en,
    output logic              r_en,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] raddr,
    output logic              wfull,
    output logic              rempty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [CNT_W-1:0] AF_CNT  = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT  = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0] PTR_ONE = CNT_W'(1);

    logic [CNT_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wfull_q, wfull_d;
    logic             rempty_q, rempty_d;
    logic             almost_full_q, almost_full_d;
    logic             almost_empty_q, almost_empty_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    // Accept decisions use the registered flags; a flush cycle accepts nothing.
    assign w_en = winc & ~wfull_q & ~flush;
    assign r_en = rinc & ~rempty_q & ~flush;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (w_en) wptr_d = wptr_q + PTR_ONE;
            if (r_en) rptr_d = rptr_q + PTR_ONE;
        end
        count_d        = wptr_d - rptr_d;
        wfull_d        = (wptr_d[ADDR_W] != rptr_d[ADDR_W]) &&
                         (wptr_d[ADDR_W-1:0] == rptr_d[ADDR_W-1:0]);
        rempty_d       = (wptr_d == rptr_d);
        almost_full_d  = (count_d >= AF_CNT);
        almost_empty_d = (count_d <= AE_CNT);
    end

    // Set beats clear when both happen together.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (!flush && winc && wfull_q)  overflow_d  = 1'b1;
        if (!flush && rinc && rempty_q) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            count_q        <= '0;
            wfull_q        <= 1'b0;
            rempty_q       <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            count_q        <= count_d;
            wfull_q        <= wfull_d;
            rempty_q       <= rempty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    assign waddr        = wptr_q[ADDR_W-1:0];
    assign raddr        = rptr_q[ADDR_W-1:0];
    assign wfull        = wfull_q;
    assign rempty       = rempty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - single-clock parametrised FIFO with registered or FWFT read
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 64,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0,
    localparam int ADDR_W  = fifo_addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             winc,
    input  logic [WIDTH-1:0] wdata,
    output logic             wfull,
    input  logic             rinc,
    output logic [WIDTH-1:0] rdata,
    output logic             rempty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ADDR_W:0]  count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    logic              w_en;
    logic              r_en;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  rdata_q, rdata_d;

    fifo_ptr_ctrl #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) u_ptr_ctrl (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .winc         (winc),
        .rinc         (rinc),
        .clr_err      (clr_err),
        .w_en         (w_en),
        .r_en         (r_en),
        .waddr        (waddr),
        .raddr        (raddr),
        .wfull        (wfull),
        .rempty       (rempty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always_ff @(posedge clk) begin
        if (w_en) mem_q[waddr] <= wdata;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (r_en) rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    // In FWFT mode the head word is shown directly; the register only backs the empty case.
    always_comb begin
        rdata = rdata_q;
        if ((FWFT == FIFO_MODE_FWFT) && !rempty) rdata = mem_q[raddr];
    end

endmodule
